// File: rtl/btn_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_run_ctrl_pkg
// Description : Shared definitions for the run/stop button controller and the
//               display / counter stages that consume its state.
//               - run_state_t : FSM state encoding (STOP = 0, RUN = 1)
//               - default clock, sample-rate and debounce-depth constants
//               - calc_div    : prescaler divide ratio helper
// Revision    : 1.0 - initial release
// ============================================================================
package btn_run_ctrl_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    localparam int unsigned c_clk_hz_default     = 100_000_000;
    localparam int unsigned c_sample_hz_default  = 1000;
    localparam int unsigned c_db_samples_default = 8;

    // Clock cycles per debounce sample; never below 1 so the prescaler
    // always has a legal terminal count.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned sample_hz);
        int unsigned div;
        div = (sample_hz == 0) ? 1 : (clk_hz / sample_hz);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_run_ctrl_if
// Description : Button / control bundle between the push-buttons and the
//               downstream counter.
//   btn_run  : raw run/stop push-button, active-high
//   btn_clr  : raw clear push-button, active-high
//   run_stop : hold request, 1 = hold count, 0 = count
//   clr      : one-cycle clear pulse
//   state    : FSM state, 0 = STOP, 1 = RUN
//   master : drives the buttons, observes the controls
//   slave  : the controller (btn_run_ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_run_ctrl_if;

    logic btn_run;
    logic btn_clr;
    logic run_stop;
    logic clr;
    logic state;

    modport master (
        output btn_run,
        output btn_clr,
        input  run_stop,
        input  clr,
        input  state
    );

    modport slave (
        input  btn_run,
        input  btn_clr,
        output run_stop,
        output clr,
        output state
    );

endinterface

`default_nettype wire

// File: rtl/btn_run_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One push-button channel: 2-flop synchronizer, sample history,
//               hysteretic debounced level and a registered press pulse.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   tick  : shared sample strobe from the prescaler
//   btn   : raw asynchronous button, active-high
//   press : one-cycle pulse on each debounced 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int unsigned DB_SAMPLES = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic tick,
    input  wire logic btn,
    output logic      press
);

    logic                  r_sync1;
    logic                  r_sync2;
    logic [DB_SAMPLES-1:0] r_hist;
    logic                  r_level;
    logic                  r_press;
    logic                  w_level_next;

    // Level only moves on a unanimous history, otherwise it holds, so any
    // bounce shorter than the history window is ignored.
    always_comb begin
        w_level_next = r_level;
        if (&r_hist) begin
            w_level_next = 1'b1;
        end else if (~|r_hist) begin
            w_level_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            if (tick) begin
                r_hist <= (r_hist << 1) | DB_SAMPLES'(r_sync2);
            end
            r_level <= w_level_next;
            // Pulse is registered alongside the level update, so it lasts
            // exactly one cycle and a held button cannot retrigger it.
            r_press <= w_level_next & ~r_level;
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/btn_run_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : btn_prescaler
// Description : Free-running divider producing the shared debounce sample
//               tick. Counts 0..DIV-1 and wraps; tick is high for the single
//               cycle in which the counter holds its terminal value.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   tick : one-cycle sample strobe
// Revision    : 1.0 - initial release
// ============================================================================
module btn_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      tick
);

    localparam int unsigned c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_terminal;

    assign w_terminal = (r_cnt == c_cnt_w'(DIV - 1));
    assign tick       = w_terminal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_terminal) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/btn_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_run_ctrl
// Description : Run/stop/clear controller for a counter. Two debounced
//               push-buttons drive a STOP/RUN FSM with registered outputs.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : btn_run_ctrl_if.slave
//          btn_run, btn_clr (in)  raw active-high buttons
//          run_stop (out)         1 = hold count (STOP), 0 = count (RUN)
//          clr (out)              one-cycle clear pulse
//          state (out)            0 = STOP, 1 = RUN
// Revision    : 1.0 - initial release
// ============================================================================
module btn_run_ctrl
    import btn_run_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ     = c_clk_hz_default,
    parameter int unsigned SAMPLE_HZ  = c_sample_hz_default,
    parameter int unsigned DB_SAMPLES = c_db_samples_default
) (
    input  wire logic      clk,
    input  wire logic      rst,
    btn_run_ctrl_if.slave  bus
);

    localparam int unsigned c_div = calc_div(CLK_HZ, SAMPLE_HZ);

    logic       w_tick;
    logic       w_run_press;
    logic       w_clr_press;
    run_state_t r_state;
    logic       r_run_stop;
    logic       r_clr;

    btn_prescaler #(
        .DIV (c_div)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    btn_debounce #(
        .DB_SAMPLES (DB_SAMPLES)
    ) u_db_run (
        .clk   (clk),
        .rst   (rst),
        .tick  (w_tick),
        .btn   (bus.btn_run),
        .press (w_run_press)
    );

    btn_debounce #(
        .DB_SAMPLES (DB_SAMPLES)
    ) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .tick  (w_tick),
        .btn   (bus.btn_clr),
        .press (w_clr_press)
    );

    // Clear has priority over run: a coincident run press is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= STOP;
            r_run_stop <= 1'b1;
            r_clr      <= 1'b0;
        end else begin
            r_clr <= w_clr_press;
            if (w_clr_press) begin
                r_state    <= STOP;
                r_run_stop <= 1'b1;
            end else if (w_run_press) begin
                case (r_state)
                    STOP: begin
                        r_state    <= RUN;
                        r_run_stop <= 1'b0;
                    end
                    RUN: begin
                        r_state    <= STOP;
                        r_run_stop <= 1'b1;
                    end
                    default: begin
                        r_state    <= STOP;
                        r_run_stop <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.run_stop = r_run_stop;
    assign bus.clr      = r_clr;
    assign bus.state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_btn_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_run_ctrl
// Description : Self-checking bench for btn_run_ctrl. A reference model turns
//               button activity into expected output events (cycle, state,
//               run_stop, clr); a monitor compares every observed output event
//               against the queue of expected ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_run_ctrl;
    import btn_run_ctrl_pkg::*;

    localparam int CLK_HZ    = 1000;
    localparam int SAMPLE_HZ = 100;
    localparam int DB        = 4;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;

    logic clk = 1'b0;
    logic rst = 1'b0;

    btn_run_ctrl_if bus ();

    btn_run_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_HZ  (SAMPLE_HZ),
        .DB_SAMPLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   edge_n;
        logic state;
        logic run_stop;
        logic clr;
    } exp_t;

    // Per-button view: current run of identical samples and debounced level.
    typedef struct {
        bit last;
        int streak;
        bit lvl;
        int due;
    } db_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // ---------------------------------------------------------------- model
    int   m_edge;
    logic m_state;
    db_t  m_run;
    db_t  m_clr;
    logic raw_run[$];
    logic raw_clr[$];

    function automatic db_t db_init();
        db_t d;
        d.last   = 1'b0;
        d.streak = DB;     // history starts out as all-zero samples
        d.lvl    = 1'b0;
        d.due    = -1;
        return d;
    endfunction

    // A level rises after DB consecutive high samples; the resulting press
    // reaches the outputs two clocks after that sample tick.
    function automatic db_t db_step(db_t d, bit s, int e);
        db_t n = d;
        if (s == n.last) n.streak++;
        else begin
            n.last   = s;
            n.streak = 1;
        end
        if (n.streak >= DB) begin
            if (s && !n.lvl) begin
                n.lvl = 1'b1;
                n.due = e + 2;
            end else if (!s) begin
                n.lvl = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_edge  = 0;
            m_state = 1'b0;
            m_run   = db_init();
            m_clr   = db_init();
            raw_run.delete();
            raw_clr.delete();
        end else begin
            bit rp, cp, sr, sc;
            m_edge++;
            rp = (m_run.due == m_edge);
            cp = (m_clr.due == m_edge);
            if (cp) begin
                m_state = 1'b0;
                exp_q.push_back('{m_edge, 1'b0, 1'b1, 1'b1});
            end else if (rp) begin
                m_state = ~m_state;
                exp_q.push_back('{m_edge, m_state, ~m_state, 1'b0});
            end
            if (m_edge % DIV == 0) begin
                // the logic sees each button through a two-clock synchronizer
                sr = (raw_run.size() >= 2) ? raw_run[raw_run.size()-2] : 1'b0;
                sc = (raw_clr.size() >= 2) ? raw_clr[raw_clr.size()-2] : 1'b0;
                m_run = db_step(m_run, sr, m_edge);
                m_clr = db_step(m_clr, sc, m_edge);
            end
            raw_run.push_back(bus.btn_run);
            raw_clr.push_back(bus.btn_clr);
            if (raw_run.size() > 2) void'(raw_run.pop_front());
            if (raw_clr.size() > 2) void'(raw_clr.pop_front());
        end
    end

    // -------------------------------------------------------------- monitor
    logic p_state    = 1'b0;
    logic p_run_stop = 1'b1;
    int   last_evt   = 0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            tests++;
            if (bus.state !== 1'b0 || bus.run_stop !== 1'b1 || bus.clr !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: got state=%b run_stop=%b clr=%b, want 0 1 0",
                         bus.state, bus.run_stop, bus.clr);
            end
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_event: cut by reset, want edge %0d state=%b clr=%b",
                         e.edge_n, e.state, e.clr);
            end
            p_state    = 1'b0;
            p_run_stop = 1'b1;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].edge_n < m_edge) begin
                exp_t e;
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_event: got no output change, want edge %0d state=%b run_stop=%b clr=%b",
                         e.edge_n, e.state, e.run_stop, e.clr);
            end
            if (bus.clr !== 1'b0 || bus.state !== p_state || bus.run_stop !== p_run_stop) begin
                tests++;
                last_evt = m_edge;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: edge %0d state=%b run_stop=%b clr=%b, want no change",
                             m_edge, bus.state, bus.run_stop, bus.clr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.edge_n != m_edge || bus.state !== e.state ||
                        bus.run_stop !== e.run_stop || bus.clr !== e.clr) begin
                        fails++;
                        $display("FAIL event: got edge %0d state=%b run_stop=%b clr=%b, want edge %0d state=%b run_stop=%b clr=%b",
                                 m_edge, bus.state, bus.run_stop, bus.clr,
                                 e.edge_n, e.state, e.run_stop, e.clr);
                    end
                end
                p_state    = bus.state;
                p_run_stop = bus.run_stop;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string name, input logic st, input logic rs);
        tests++;
        if (bus.state !== st || bus.run_stop !== rs || bus.clr !== 1'b0) begin
            fails++;
            $display("FAIL %s: got state=%b run_stop=%b clr=%b, want %b %b 0",
                     name, bus.state, bus.run_stop, bus.clr, st, rs);
        end
    endtask

    initial begin
        int t_press;
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;

        // idle after reset: nothing may move
        wait_clk(200);
        check_out("idle", 1'b0, 1'b1);

        // clean run press, then release
        t_press = m_edge;
        bus.btn_run = 1'b1;
        wait_clk(60);
        bus.btn_run = 1'b0;
        wait_clk(60);
        check_out("run_press", 1'b1, 1'b0);
        tests++;
        if (last_evt - t_press > 44 || last_evt <= t_press) begin
            fails++;
            $display("FAIL press_latency: got %0d clk, want 1..44", last_evt - t_press);
        end

        // bounce every 3 clk, then a steady hold: RUN -> STOP
        for (int i = 0; i < 10; i++) begin
            bus.btn_run = ~bus.btn_run;
            wait_clk(3);
        end
        bus.btn_run = 1'b1;
        wait_clk(80);
        bus.btn_run = 1'b0;
        wait_clk(60);
        check_out("bounce_then_hold", 1'b0, 1'b1);

        // back to RUN, then clear
        bus.btn_run = 1'b1;
        wait_clk(60);
        bus.btn_run = 1'b0;
        wait_clk(60);
        check_out("rerun", 1'b1, 1'b0);
        bus.btn_clr = 1'b1;
        wait_clk(60);
        bus.btn_clr = 1'b0;
        wait_clk(60);
        check_out("clear_in_run", 1'b0, 1'b1);

        // simultaneous run + clear in STOP: clear wins
        bus.btn_run = 1'b1;
        bus.btn_clr = 1'b1;
        wait_clk(60);
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        wait_clk(60);
        check_out("run_and_clear", 1'b0, 1'b1);

        // reset in the middle of a debounce, button still held
        bus.btn_run = 1'b1;
        wait_clk(25);
        rst = 1'b0;
        wait_clk(1);
        rst = 1'b1;
        wait_clk(80);
        bus.btn_run = 1'b0;
        wait_clk(60);
        check_out("reset_mid_debounce", 1'b1, 1'b0);

        // randomized bouncy activity with occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            logic lr, lc;
            int   len;
            lr  = 1'($urandom_range(0, 1));
            lc  = ($urandom_range(0, 3) == 0);
            len = $urandom_range(5, 70);
            for (int c = 0; c < len; c++) begin
                bus.btn_run = lr ^ ($urandom_range(0, 7) == 0);
                bus.btn_clr = lc ^ ($urandom_range(0, 9) == 0);
                wait_clk(1);
            end
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                wait_clk($urandom_range(1, 3));
                rst = 1'b1;
            end
        end
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        wait_clk(80);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending events, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_run_ctrl.md
BTN_RUN_CTRL -- requirements
Module: btn_run_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter SAMPLE_HZ, default 1000: debounce sampling rate in Hz.
REQ-003 Parameter DB_SAMPLES, default 8: consecutive equal samples required to accept a new button level.
REQ-004 clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 btn_run  input  1  raw, asynchronous, bouncing run/stop push-button; active-high.
REQ-007 btn_clr  input  1  raw, asynchronous, bouncing clear push-button; active-high.
REQ-008 run_stop  output  1  hold request to the downstream counter: 1 = hold count, 0 = count.
REQ-009 clr  output  1  one-cycle clear pulse to the downstream counter.
REQ-010 state  output  1  current FSM state: 0 = STOP, 1 = RUN.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic sees it.
REQ-012 A prescaler SHALL count 0..(CLK_HZ/SAMPLE_HZ - 1), wrap to 0, and assert a one-cycle sample tick on the terminal count.
REQ-013 On each sample tick, each synchronized button SHALL shift into a DB_SAMPLES-bit history register.
REQ-014 The debounced level SHALL go to 1 when the history is all ones, go to 0 when it is all zeros, and otherwise hold its value.
REQ-015 A 0->1 change of a debounced level SHALL produce exactly one registered press pulse, 1 clk wide, in the cycle after the change; a release SHALL produce no pulse.
REQ-016 A held button SHALL produce only one press pulse, regardless of hold duration.
REQ-017 FSM, STOP: a run press SHALL move to RUN; a clear press SHALL stay in STOP.
REQ-018 FSM, RUN: a run press SHALL move to STOP; a clear press SHALL move to STOP.
REQ-019 run_stop SHALL be registered and equal to 1 in STOP and 0 in RUN, updating in the same edge as the state change.
REQ-020 A clear press SHALL assert clr for exactly 1 clk, on the same edge that applies the FSM transition.
REQ-021 If run and clear presses occur in the same cycle, clear SHALL win: clr is pulsed and the next state is STOP.
REQ-022 Bounce shorter than DB_SAMPLES sample periods SHALL NOT change a debounced level or generate a pulse.
REQ-023 Worst-case press-to-output latency SHALL be 2 (synchronizer) + DB_SAMPLES*CLK_HZ/SAMPLE_HZ + 2 clk.

Reset
REQ-024 While rst = 0, the following SHALL be cleared immediately and asynchronously: prescaler = 0, history registers = 0, debounced levels = 0, state = STOP, run_stop = 1, clr = 0.
REQ-025 After rst deasserts, a button already held down SHALL produce one press pulse once it is debounced.
REQ-026 Reset asserted mid-debounce or mid-pulse SHALL abort the debounce and suppress the pending pulse.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (STOP = 1'b0, RUN = 1'b1) and default parameter constants, for reuse by the display and counter stages.
REQ-028 Debounce logic SHALL be one sub-module, btn_debounce (synchronizer, history, level, press pulse), instantiated twice.
REQ-029 The prescaler SHALL be instantiated once and its sample tick shared by both btn_debounce instances.

Verification
Benches SHALL use CLK_HZ = 1000, SAMPLE_HZ = 100 (divider 10) and DB_SAMPLES = 4.
REQ-030 Reset released with buttons idle -> run_stop = 1, clr = 0, state = STOP; outputs stay unchanged for 200 clk.
REQ-031 btn_run held clean for 60 clk, then released -> exactly one state change to RUN, run_stop = 0, within 44 clk of the press; the release causes no change.
REQ-032 btn_run toggled every 3 clk for 30 clk, then held -> no output change during the bounce; one transition follows once the button has been stable for 4 ticks.
REQ-033 In RUN, btn_clr held for 60 clk -> clr high for exactly 1 clk, state = STOP, run_stop = 1.
REQ-034 btn_run and btn_clr pressed on the same clk edge while in STOP -> debounced pulses coincide; clr pulses once and state stays STOP.
REQ-035 btn_run pressed, and rst pulsed low for 1 clk 25 clk later -> no press pulse, state = STOP; because btn_run is still held, one RUN transition occurs after rst deasserts, once the button is re-debounced.
